// File: rtl/snake_move_ctrl.sv
// Snake head movement controller: tick-divided stepping, buffered direction
// input with reverse rejection, wall-collision detection and length tracking.
module snake_move_ctrl #(
  parameter int         TICK_DIV  = 25000000,
  parameter int         GRID_H    = 30,
  parameter int         GRID_W    = 40,
  parameter int         START_X   = 15,
  parameter int         START_Y   = 20,
  parameter logic [1:0] START_WAY = 2'd2,
  parameter int         MAX_LEN   = 63
) (
  input  logic       i_Clk,
  input  logic       i_Rst,
  input  logic       i_Start,
  input  logic       i_Pause,
  input  logic       i_Btn_Valid,
  input  logic [1:0] i_Btn_Way,
  input  logic       i_Grow,
  output logic [5:0] o_Head_x,
  output logic [5:0] o_Head_y,
  output logic [1:0] o_Way,
  output logic       o_Step,
  output logic       o_Dead,
  output logic [5:0] o_Len
);

  localparam int CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0]  LP_TICK_LAST = CNT_W'(TICK_DIV - 1);
  localparam logic signed [6:0] LP_H         = 7'(GRID_H);
  localparam logic signed [6:0] LP_W         = 7'(GRID_W);
  localparam logic [5:0]        LP_MAX_LEN   = 6'(MAX_LEN);

  localparam logic [1:0] WAY_UP    = 2'd0;
  localparam logic [1:0] WAY_DOWN  = 2'd1;
  localparam logic [1:0] WAY_RIGHT = 2'd2;
  localparam logic [1:0] WAY_LEFT  = 2'd3;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_STEP, S_DEAD} state_t;

  state_t           r_State;
  logic [CNT_W-1:0] r_Tick;
  logic [1:0]       r_Pend;
  logic [5:0]       r_Head_x;
  logic [5:0]       r_Head_y;
  logic [1:0]       r_Way;
  logic             r_Step;
  logic             r_Dead;
  logic [5:0]       r_Len;

  logic signed [6:0] w_Nx;
  logic signed [6:0] w_Ny;
  logic              w_Out;
  logic              w_Reverse;
  logic [5:0]        w_Len_inc;

  // One extra bit lets 0-1 appear as negative instead of wrapping to 63.
  always_comb begin
    w_Nx = $signed({1'b0, r_Head_x});
    w_Ny = $signed({1'b0, r_Head_y});
    case (r_Pend)
      WAY_UP:    w_Nx = $signed({1'b0, r_Head_x}) - 7'sd1;
      WAY_DOWN:  w_Nx = $signed({1'b0, r_Head_x}) + 7'sd1;
      WAY_RIGHT: w_Ny = $signed({1'b0, r_Head_y}) + 7'sd1;
      WAY_LEFT:  w_Ny = $signed({1'b0, r_Head_y}) - 7'sd1;
      default:   w_Nx = $signed({1'b0, r_Head_x});
    endcase
    w_Out = (w_Nx < 7'sd0) || (w_Nx >= LP_H) || (w_Ny < 7'sd0) || (w_Ny >= LP_W);
  end

  // Reverse pairs differ only in bit 0 (UP/DOWN, RIGHT/LEFT).
  assign w_Reverse = ((i_Btn_Way ^ r_Way) == 2'b01);
  assign w_Len_inc = (r_Len >= LP_MAX_LEN) ? LP_MAX_LEN : r_Len + 6'd1;

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      r_State  <= S_IDLE;
      r_Tick   <= '0;
      r_Pend   <= START_WAY;
      r_Head_x <= 6'(START_X);
      r_Head_y <= 6'(START_Y);
      r_Way    <= START_WAY;
      r_Step   <= 1'b0;
      r_Dead   <= 1'b0;
      r_Len    <= 6'd3;
    end else begin
      r_Step <= 1'b0;
      case (r_State)
        S_IDLE: begin
          if (i_Start) begin
            r_State <= S_RUN;
            r_Tick  <= '0;
            r_Pend  <= r_Way;
          end
        end
        S_RUN: begin
          if (i_Btn_Valid && !w_Reverse) r_Pend <= i_Btn_Way;
          if (i_Grow) r_Len <= w_Len_inc;
          if (!i_Pause) begin
            if (r_Tick == LP_TICK_LAST) begin
              r_Tick  <= '0;
              r_State <= S_STEP;
            end else begin
              r_Tick <= r_Tick + CNT_W'(1);
            end
          end
        end
        S_STEP: begin
          if (i_Grow) r_Len <= w_Len_inc;
          if (!w_Out) begin
            r_Head_x <= w_Nx[5:0];
            r_Head_y <= w_Ny[5:0];
            r_Way    <= r_Pend;
            r_Step   <= 1'b1;
            r_State  <= S_RUN;
          end else begin
            r_Dead  <= 1'b1;
            r_State <= S_DEAD;
          end
        end
        S_DEAD: begin
          if (i_Start) begin
            r_Head_x <= 6'(START_X);
            r_Head_y <= 6'(START_Y);
            r_Way    <= START_WAY;
            r_Len    <= 6'd3;
            r_Dead   <= 1'b0;
            r_State  <= S_IDLE;
          end
        end
        default: r_State <= S_IDLE;
      endcase
    end
  end

  assign o_Head_x = r_Head_x;
  assign o_Head_y = r_Head_y;
  assign o_Way    = r_Way;
  assign o_Step   = r_Step;
  assign o_Dead   = r_Dead;
  assign o_Len    = r_Len;

endmodule

// File: tb/tb_snake_move_ctrl.sv
// Bench for snake_move_ctrl: directed scenarios plus randomized run against
// an event-level reference model of the snake game rules.
module tb_snake_move_ctrl;

  localparam int TD = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0, start = 1'b0, pause = 1'b0, bv = 1'b0, grow = 1'b0;
  logic [1:0] bw = 2'd0;
  logic [5:0] hx, hy, len, whx, why, wlen;
  logic [1:0] way, wway;
  logic       step, dead, wstep, wdead;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  snake_move_ctrl #(.TICK_DIV(TD)) dut (
    .i_Clk(clk), .i_Rst(rst), .i_Start(start), .i_Pause(pause),
    .i_Btn_Valid(bv), .i_Btn_Way(bw), .i_Grow(grow),
    .o_Head_x(hx), .o_Head_y(hy), .o_Way(way), .o_Step(step),
    .o_Dead(dead), .o_Len(len)
  );

  snake_move_ctrl #(.TICK_DIV(TD), .START_X(0), .START_WAY(2'd0)) wall (
    .i_Clk(clk), .i_Rst(rst), .i_Start(start), .i_Pause(pause),
    .i_Btn_Valid(bv), .i_Btn_Way(bw), .i_Grow(grow),
    .o_Head_x(whx), .o_Head_y(why), .o_Way(wway), .o_Step(wstep),
    .o_Dead(wdead), .o_Len(wlen)
  );

  // Reference model: game mode, RUN cycles elapsed, head as plain integers.
  localparam int M_IDLE = 0, M_RUN = 1, M_STEP = 2, M_DEAD = 3;
  int DX [4] = '{-1, 1, 0, 0};
  int DY [4] = '{0, 0, 1, -1};
  int OPP [4] = '{1, 0, 3, 2};
  int m_mode, m_elapsed, m_x, m_y, m_way, m_pend, m_len;
  bit m_step, m_dead;

  task automatic model_edge(input bit r, s, p, v, input int w, input bit g);
    int nx, ny;
    if (r) begin
      m_mode = M_IDLE; m_elapsed = 0; m_x = 15; m_y = 20; m_way = 2; m_pend = 2;
      m_len = 3; m_step = 0; m_dead = 0;
      return;
    end
    m_step = 0;
    case (m_mode)
      M_IDLE: if (s) begin m_mode = M_RUN; m_elapsed = 0; m_pend = m_way; end
      M_RUN: begin
        if (v && w != OPP[m_way]) m_pend = w;
        if (g && m_len < 63) m_len++;
        if (!p) begin
          m_elapsed++;
          if (m_elapsed == TD) begin m_elapsed = 0; m_mode = M_STEP; end
        end
      end
      M_STEP: begin
        if (g && m_len < 63) m_len++;
        nx = m_x + DX[m_pend];
        ny = m_y + DY[m_pend];
        if (nx >= 0 && nx < 30 && ny >= 0 && ny < 40) begin
          m_x = nx; m_y = ny; m_way = m_pend; m_step = 1; m_mode = M_RUN;
        end else begin
          m_dead = 1; m_mode = M_DEAD;
        end
      end
      default: if (s) begin
        m_x = 15; m_y = 20; m_way = 2; m_len = 3; m_dead = 0; m_mode = M_IDLE;
      end
    endcase
  endtask

  // Drive one cycle of inputs from a falling edge, return at the next falling edge.
  task automatic cyc(input bit r, s, p, v, input logic [1:0] w, input bit g);
    rst = r; start = s; pause = p; bv = v; bw = w; grow = g;
    @(posedge clk);
    model_edge(r, s, p, v, int'(w), g);
    @(negedge clk);
    rst = 0; start = 0; pause = 0; bv = 0; bw = 0; grow = 0;
  endtask

  task automatic idle();
    cyc(0, 0, 0, 0, 2'd0, 0);
  endtask

  task automatic wait_step(output int n, output bit ok);
    n = 0; ok = 0;
    for (int i = 0; i < 40; i++) begin
      idle(); n++;
      if (step === 1'b1) begin ok = 1; break; end
    end
  endtask

  task automatic wait_model_step(output bit ok);
    ok = 0;
    for (int i = 0; i < 40; i++) begin
      if (m_mode == M_STEP) begin ok = 1; break; end
      idle();
    end
  endtask

  task automatic reset_and_start();
    cyc(1, 0, 0, 0, 2'd0, 0);
    cyc(1, 0, 0, 0, 2'd0, 0);
    cyc(0, 1, 0, 0, 2'd0, 0);
  endtask

  task automatic test_reset();
    cyc(1, 0, 0, 0, 2'd0, 0);
    cyc(1, 1, 1, 1, 2'd0, 1);
    checks++; if ({hx, hy} !== {6'd15, 6'd20}) begin failures++;
      $display("FAIL reset_head got=(%0d,%0d) exp=(15,20)", hx, hy); end
    checks++; if ({way, step, dead, len} !== {2'd2, 1'b0, 1'b0, 6'd3}) begin failures++;
      $display("FAIL reset_ctrl got way=%0d step=%0d dead=%0d len=%0d exp 2/0/0/3", way, step, dead, len); end
    checks++; if ({whx, why, wway} !== {6'd0, 6'd20, 2'd0}) begin failures++;
      $display("FAIL reset_wall got=(%0d,%0d) way=%0d exp=(0,20) way=0", whx, why, wway); end
  endtask

  task automatic test_basic_step();
    int n; bit ok;
    reset_and_start();
    wait_step(n, ok);
    checks++; if (!ok || n != TD + 1) begin failures++;
      $display("FAIL basic_first_latency got=%0d ok=%0d exp=%0d", n, ok, TD + 1); end
    checks++; if ({hx, hy, way} !== {6'd15, 6'd21, 2'd2}) begin failures++;
      $display("FAIL basic_first_head got=(%0d,%0d) way=%0d exp=(15,21) way=2", hx, hy, way); end
    idle();
    checks++; if (step !== 1'b0) begin failures++;
      $display("FAIL basic_step_width got=%0d exp=0", step); end
    wait_step(n, ok);
    checks++; if (!ok || n != TD || hy !== 6'd22) begin failures++;
      $display("FAIL basic_period got n=%0d y=%0d exp n=%0d y=22", n + 1, hy, TD + 1); end
  endtask

  task automatic test_reverse();
    int n; bit ok;
    reset_and_start();
    cyc(0, 0, 0, 1, 2'd3, 0);
    wait_step(n, ok);
    checks++; if (!ok || {hx, hy, way} !== {6'd15, 6'd21, 2'd2}) begin failures++;
      $display("FAIL reverse_drop got=(%0d,%0d) way=%0d exp=(15,21) way=2", hx, hy, way); end
    cyc(0, 0, 0, 1, 2'd0, 0);
    wait_step(n, ok);
    checks++; if (!ok || {hx, hy, way} !== {6'd14, 6'd21, 2'd0}) begin failures++;
      $display("FAIL reverse_turn got=(%0d,%0d) way=%0d exp=(14,21) way=0", hx, hy, way); end
  endtask

  task automatic test_last_press();
    int n; bit ok;
    reset_and_start();
    cyc(0, 0, 0, 1, 2'd0, 0);
    cyc(0, 0, 0, 1, 2'd1, 0);
    wait_step(n, ok);
    checks++; if (!ok || {hx, hy, way} !== {6'd16, 6'd20, 2'd1}) begin failures++;
      $display("FAIL last_press got=(%0d,%0d) way=%0d exp=(16,20) way=1", hx, hy, way); end
  endtask

  task automatic test_wall_hit();
    bit seen_step = 0;
    int n = 0;
    reset_and_start();
    while (wdead !== 1'b1 && n < 20) begin
      idle(); n++;
      if (wstep === 1'b1) seen_step = 1;
    end
    checks++; if (wdead !== 1'b1 || n != TD + 1) begin failures++;
      $display("FAIL wall_dead got dead=%0d after %0d exp dead=1 after %0d", wdead, n, TD + 1); end
    checks++; if ({whx, why, wway, seen_step} !== {6'd0, 6'd20, 2'd0, 1'b0}) begin failures++;
      $display("FAIL wall_hold got=(%0d,%0d) way=%0d step_seen=%0d exp=(0,20) 0 0", whx, why, wway, seen_step); end
    idle(); idle();
    checks++; if ({wdead, whx, why} !== {1'b1, 6'd0, 6'd20}) begin failures++;
      $display("FAIL wall_dead_hold got dead=%0d (%0d,%0d) exp 1 (0,20)", wdead, whx, why); end
    cyc(0, 1, 0, 0, 2'd0, 0);
    checks++; if ({wdead, whx, why, wlen} !== {1'b0, 6'd0, 6'd20, 6'd3}) begin failures++;
      $display("FAIL wall_restart got dead=%0d (%0d,%0d) len=%0d exp 0 (0,20) 3", wdead, whx, why, wlen); end
  endtask

  task automatic test_pause();
    int n; bit ok;
    reset_and_start();
    idle(); idle();
    for (int i = 0; i < 10; i++) cyc(0, 0, 1, 0, 2'd0, 0);
    wait_step(n, ok);
    checks++; if (!ok || n + 12 != TD + 1 + 10) begin failures++;
      $display("FAIL pause_delay got=%0d exp=%0d", n + 12, TD + 11); end
  endtask

  task automatic test_grow();
    bit ok;
    reset_and_start();
    wait_model_step(ok);
    cyc(0, 0, 0, 0, 2'd0, 1);
    checks++; if (!ok || {len, step, hy} !== {6'd4, 1'b1, 6'd21}) begin failures++;
      $display("FAIL grow_at_step got len=%0d step=%0d y=%0d exp 4 1 21", len, step, hy); end
    for (int i = 0; i < 70; i++) cyc(0, 0, 0, 0, 2'd0, 1);
    checks++; if ({len, dead} !== {6'd63, 1'b0}) begin failures++;
      $display("FAIL grow_saturate got len=%0d dead=%0d exp 63 0", len, dead); end
    checks++; if (hy !== 6'(m_y)) begin failures++;
      $display("FAIL grow_head got y=%0d exp=%0d", hy, m_y); end
  endtask

  task automatic test_reset_in_step();
    bit ok;
    reset_and_start();
    wait_model_step(ok);
    cyc(1, 0, 0, 0, 2'd0, 1);
    checks++; if (!ok || {hx, hy, step, len, dead} !== {6'd15, 6'd20, 1'b0, 6'd3, 1'b0}) begin failures++;
      $display("FAIL reset_step got=(%0d,%0d) step=%0d len=%0d dead=%0d exp (15,20) 0 3 0", hx, hy, step, len, dead); end
    for (int i = 0; i < 2 * TD + 4; i++) idle();
    checks++; if ({hy, step} !== {6'd20, 1'b0}) begin failures++;
      $display("FAIL reset_step_idle got y=%0d step=%0d exp 20 0", hy, step); end
  endtask

  task automatic test_random();
    int bad = 0;
    cyc(1, 0, 0, 0, 2'd0, 0);
    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom_range(0, 499) == 0), ($urandom_range(0, 29) == 0),
          ($urandom_range(0, 3) == 0), ($urandom_range(0, 5) == 0),
          2'($urandom_range(0, 3)), ($urandom_range(0, 7) == 0));
      checks++;
      if ({hx, hy, way, step, dead, len} !==
          {6'(m_x), 6'(m_y), 2'(m_way), m_step, m_dead, 6'(m_len)}) begin
        failures++; bad++;
        if (bad <= 10)
          $display("FAIL random_cycle%0d got x=%0d y=%0d way=%0d step=%0d dead=%0d len=%0d exp x=%0d y=%0d way=%0d step=%0d dead=%0d len=%0d",
                   i, hx, hy, way, step, dead, len, m_x, m_y, m_way, m_step, m_dead, m_len);
      end
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_basic_step();
    test_reverse();
    test_last_press();
    test_wall_hit();
    test_pause();
    test_grow();
    test_reset_in_step();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/snake_move_ctrl.md
SNAKE_MOVE_CTRL -- requirements
Module: snake_move_ctrl

Interface
REQ-001 The block SHALL have parameter TICK_DIV, default 25000000, meaning RUN cycles counted per move step (minimum 2).
REQ-002 The block SHALL have parameter GRID_H, default 30, meaning number of rows; x is the row index, 0..GRID_H-1.
REQ-003 The block SHALL have parameter GRID_W, default 40, meaning number of columns; y is the column index, 0..GRID_W-1.
REQ-004 The block SHALL have parameters START_X, default 15, and START_Y, default 20, meaning the initial head position.
REQ-005 The block SHALL have parameter START_WAY, default 2 (RIGHT), meaning the initial direction.
REQ-006 The block SHALL have parameter MAX_LEN, default 63, meaning the snake length saturation value.
REQ-007 The block SHALL have port i_Clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-008 The block SHALL have port i_Rst, input, 1 bit: reset, synchronous and active-high.
REQ-009 The block SHALL have port i_Start, input, 1 bit: level-sampled start or restart request.
REQ-010 The block SHALL have port i_Pause, input, 1 bit: while high, tick counting is frozen.
REQ-011 The block SHALL have port i_Btn_Valid, input, 1 bit: one-cycle strobe qualifying i_Btn_Way.
REQ-012 The block SHALL have port i_Btn_Way, input, 2 bits: requested direction; UP=0, DOWN=1, RIGHT=2, LEFT=3.
REQ-013 The block SHALL have port i_Grow, input, 1 bit: one-cycle food-eaten strobe.
REQ-014 The block SHALL have ports o_Head_x and o_Head_y, output, 6 bits each: registered head position.
REQ-015 The block SHALL have port o_Way, output, 2 bits: registered committed direction.
REQ-016 The block SHALL have port o_Step, output, 1 bit: one-cycle pulse marking a head update.
REQ-017 The block SHALL have port o_Dead, output, 1 bit: high while in state DEAD.
REQ-018 The block SHALL have port o_Len, output, 6 bits: current snake length.

Function
REQ-019 The FSM SHALL have four states: IDLE, RUN, STEP and DEAD.
REQ-020 IDLE SHALL go to RUN when i_Start=1, clearing the tick counter and the pending direction to o_Way.
REQ-021 In RUN with i_Pause=0, the tick counter SHALL increment; at count TICK_DIV-1 it SHALL clear and the FSM SHALL enter STEP.
REQ-022 In RUN with i_Pause=1, the tick counter SHALL hold its value and the FSM SHALL stay in RUN.
REQ-023 STEP SHALL last exactly one cycle; in it, the way to commit (W) SHALL be the pending direction.
REQ-024 Next-head rule: UP gives x-1; DOWN gives x+1; LEFT gives y-1; RIGHT gives y+1; the other coordinate is unchanged.
REQ-025 Out-of-range checks SHALL use 7-bit arithmetic so that 0-1 is detected as out of range, not wrapped to 63.
REQ-026 If the next head is in range, at the STEP clock edge the block SHALL load the head registers, set o_Way=W and set o_Step=1, then go to RUN.
REQ-027 o_Step SHALL therefore be high in the first RUN cycle after STEP; the step period SHALL be TICK_DIV+1 cycles with no pause.
REQ-028 If the next head is out of range (x or y <0, x>=GRID_H or y>=GRID_W), the head registers and o_Way SHALL be unchanged, o_Step SHALL stay 0, and the FSM SHALL go to DEAD.
REQ-029 A button press (i_Btn_Valid=1) in RUN SHALL load the pending direction only if i_Btn_Way is not the reverse of o_Way (UP/DOWN, LEFT/RIGHT are reverse pairs).
REQ-030 A reverse request SHALL be dropped with no effect.
REQ-031 If several button presses occur before one step, the last accepted press SHALL win.
REQ-032 The reverse check SHALL always compare against the committed o_Way, never against the pending direction.
REQ-033 A button press in IDLE, STEP or DEAD SHALL be ignored.
REQ-034 i_Grow SHALL increment o_Len by 1, saturating at MAX_LEN, in the states RUN and STEP; it SHALL be ignored in IDLE and DEAD.
REQ-035 If i_Grow and the STEP edge occur together, both the increment and the head update SHALL take effect.
REQ-036 In DEAD, the block SHALL hold all outputs.
REQ-037 From DEAD, i_Start=1 SHALL load head=(START_X,START_Y), o_Way=START_WAY and o_Len=3, and go to IDLE.
REQ-038 i_Pause SHALL have no effect outside RUN.

Reset
REQ-039 When i_Rst=1 at a clock edge, the block SHALL enter IDLE and clear the tick counter.
REQ-040 Reset SHALL set o_Head_x=START_X, o_Head_y=START_Y, o_Way=START_WAY, pending direction=START_WAY, o_Step=0, o_Dead=0 and o_Len=3.
REQ-041 Reset SHALL take priority over every other input, including reset asserted in the middle of STEP or while paused.

Verification
REQ-042 Scenario "basic step" (TICK_DIV=4, defaults): reset, then i_Start=1 for one cycle -> o_Step first pulses 4 cycles after entry to RUN plus the STEP cycle, with head (15,21); every 5 cycles after that, y increments by 1.
REQ-043 Scenario "reverse rejected": in RUN with o_Way=RIGHT, press LEFT -> next step gives head y+1 and o_Way=2; then press UP -> next step gives x-1 and o_Way=0.
REQ-044 Scenario "last press wins": in one tick window with o_Way=RIGHT, press UP then DOWN -> both are accepted, and the step gives x+1 and o_Way=1.
REQ-045 Scenario "wall hit": START_X=0, START_WAY=UP -> at the first step o_Dead=1, head stays (0,20), no o_Step pulse; then i_Start -> IDLE with head (0,20) and o_Len=3.
REQ-046 Scenario "pause": assert i_Pause for 10 cycles in mid-count -> the step is delayed by exactly 10 cycles.
REQ-047 Scenario "grow saturation": 70 i_Grow pulses -> o_Len=63; a pulse coincident with STEP -> both the length and the head update.
REQ-048 Scenario "reset during STEP": i_Rst=1 in the STEP cycle -> next cycle is IDLE with head (15,20), o_Step=0 and o_Len=3.
